pi_sig_decim: RTL
=================

Name: pi_sig_decim

Overview:
- Decimating boxcar averager directly upstream of the PI feedback loop.
- Takes a fast signed sample stream with a per-sample valid, averages 2^log_dec samples, and emits one full-scale signed OW-bit result with a single-cycle strobe.
- Its dout/strobe_out connect straight to the loop's sigin/strobe_in.
- Sets the loop update rate and rejects in-band noise ahead of the PI arithmetic.

Parameters:
- DW, 16, input sample width (signed).
- OW, 18, output width (signed); OW >= DW; result is left-justified by OW-DW bits.
- LOG_MAX, 7, maximum log2 decimation (window up to 128 samples).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- din  in  DW  signed input sample.
- din_valid  in  1  din is a sample this cycle.
- log_dec  in  3  log2 of window length, 0..LOG_MAX; values above LOG_MAX clamp to LOG_MAX.
- enable  in  1  0 = block idle, accumulator cleared.
- sync  in  1  single-cycle pulse; abandons the partial window and restarts it.
- offset  in  OW  signed offset; present only with PI_SIG_OFFSET_EN.
- dout  out  OW  signed averaged sample (to PI sigin).
- strobe_out  out  1  one-cycle pulse, dout newly valid (to PI strobe_in).
- sat  out  1  sticky saturation flag; cleared by rst or sync.

Behaviour:
- Reset (async, rst=1): acc=0, cnt=0, dout=0, strobe_out=0, sat=0, latched window length = 0.
- Internal accumulator: signed DW+LOG_MAX bits; no overflow possible.
- Sample counter: LOG_MAX+1 bits.
- Window start (cnt==0):
  - log_dec is latched, clamped to LOG_MAX.
  - Changes mid-window have no effect until the next window.
- Each cycle with enable=1, din_valid=1, sync=0:
  - acc += din; cnt += 1.
  - If cnt reaches 2^L_latched on this sample:
    - next cycle: dout = ((acc_final sign-extended) <<< (OW-DW)) >>> L_latched, floor rounding (arithmetic shift); strobe_out=1 for exactly one cycle.
    - acc and cnt return to 0 in the same edge.
- Latency: strobe_out rises one clock after the rising edge that captured the window's last sample.
- L=0: pure registered pass-through; dout = din <<< (OW-DW), a strobe per valid sample.
- din_valid=0: no change; gaps between samples are allowed and do not extend or end the window.
- sync=1:
  - acc, cnt cleared; no strobe; log_dec re-latched.
  - If din_valid=1 in the same cycle, that sample is the first sample of the new window (acc=din, cnt=1).
- enable=0:
  - acc, cnt held at 0; strobe_out=0; dout holds its last value.
  - Re-enabling starts a fresh window.
- dout changes only on a strobe cycle; it is stable between strobes.
- Rst mid-window discards the partial window; the first strobe after reset needs a full window.

Optional Feature:
- Macro PI_SIG_OFFSET_EN.
- Defined:
  - Port offset exists.
  - dout = saturate_OW(average - offset), computed with one guard bit.
  - On clipping, dout = +(2^(OW-1)-1) or -2^(OW-1), and sat sets (sticky).
  - Latency unchanged; subtract and saturate are combinational ahead of the dout register.
- Undefined:
  - No offset port.
  - sat is tied to 0.
  - dout is the raw average.

Decomposition:
- Package pi_sig_pkg holds:
  - default widths DW/OW/LOG_MAX;
  - accumulator width constant ACC_W = DW+LOG_MAX;
  - a function sat_trunc(value, width) shared with other loop-path blocks.
- One natural sub-module, pi_sig_scale: combinational shift/offset/saturate from acc_final to OW bits.
- Counter, accumulator and strobe logic stay in the top.

Test Plan:
- L=0, din=1000 valid every cycle -> strobe_out every cycle, dout=4000 one cycle after each sample.
- L=2, din=1000 valid every 3rd cycle -> one strobe per 4 samples, dout=4000, strobe one clock after the 4th sample, dout stable between strobes.
- L=1, samples -1,-2 -> dout=-6 (floor: -12>>>1); L=2, samples -1,0,0,0 -> dout=-1.
- L=3 window, sync asserted with din_valid after 5 samples -> no strobe; next strobe after the sync sample plus 7 more samples; log_dec changed mid-window to 1 -> ignored until the window boundary.
- rst pulsed mid-window and while strobe_out=1 -> dout=0, strobe_out=0 immediately (async); next strobe only after a full new window.
- PI_SIG_OFFSET_EN, L=0, din=32767, offset=-10000 -> dout=131071, sat=1, held until sync; offset=1000, din=500 -> dout=1000.

Source files
------------

// File: rtl/pi_sig_pkg.sv
// Shared widths and helpers for the PI loop signal path.
package pi_sig_pkg;

  localparam int DW_DEF      = 16;
  localparam int OW_DEF      = 18;
  localparam int LOG_MAX_DEF = 7;
  localparam int ACC_W       = DW_DEF + LOG_MAX_DEF;
  localparam int WIDE_W      = 64;

  // Clamp a wide signed value into the signed range of 'width' bits.
  function automatic logic signed [WIDE_W-1:0] sat_trunc(
    input logic signed [WIDE_W-1:0] value,
    input int                       width
  );
    logic signed [WIDE_W-1:0] hi;
    logic signed [WIDE_W-1:0] lo;
    hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (value > hi) return hi;
    if (value < lo) return lo;
    return value;
  endfunction

endpackage

// File: rtl/pi_sig_decim_if.sv
// Sample stream in, averaged stream out, for the PI signal decimator.
interface pi_sig_decim_if #(
  parameter int DW = 16,
  parameter int OW = 18
);
  logic signed [DW-1:0] din;
  logic                 din_valid;
  logic signed [OW-1:0] dout;
  logic                 strobe_out;
  logic                 sat;

  modport master (output din, din_valid, input dout, strobe_out, sat);
  modport slave  (input din, din_valid, output dout, strobe_out, sat);
endinterface

// File: rtl/pi_sig_scale.sv
// Combinational left-justify, window divide and (with PI_SIG_OFFSET_EN) offset/saturate.
module pi_sig_scale
  import pi_sig_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int OW      = OW_DEF,
  parameter int LOG_MAX = LOG_MAX_DEF
) (
  input  logic signed [DW+LOG_MAX-1:0] acc_final,
  input  logic        [2:0]            shift,
`ifdef PI_SIG_OFFSET_EN
  input  logic signed [OW-1:0]         offset,
  output logic                         clip,
`endif
  output logic signed [OW-1:0]         result
);

  localparam int AW = DW + LOG_MAX;

  logic signed [WIDE_W-1:0] wide;
`ifdef PI_SIG_OFFSET_EN
  logic signed [WIDE_W-1:0] avg;
  logic signed [WIDE_W-1:0] diff;
  logic signed [WIDE_W-1:0] clipped;
`endif

  always_comb begin
    wide = {{(WIDE_W-AW){acc_final[AW-1]}}, acc_final};
`ifdef PI_SIG_OFFSET_EN
    avg     = (wide <<< (OW - DW)) >>> shift;
    diff    = avg - {{(WIDE_W-OW){offset[OW-1]}}, offset};
    clipped = sat_trunc(diff, OW);
    result  = clipped[OW-1:0];
    clip    = (clipped != diff);
`else
    // The window average always fits in OW bits, so truncation is exact.
    result  = OW'((wide <<< (OW - DW)) >>> shift);
`endif
  end

endmodule

// File: rtl/pi_sig_decim.sv
// Decimating boxcar averager feeding the PI loop; optional offset/saturation under PI_SIG_OFFSET_EN.
module pi_sig_decim
  import pi_sig_pkg::*;
#(
  parameter int DW      = DW_DEF,
  parameter int OW      = OW_DEF,
  parameter int LOG_MAX = LOG_MAX_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  pi_sig_decim_if.slave        bus,
  input  logic [2:0]           log_dec,
  input  logic                 enable,
`ifdef PI_SIG_OFFSET_EN
  input  logic signed [OW-1:0] offset,
`endif
  input  logic                 sync
);

  localparam int AW = DW + LOG_MAX;
  localparam int CW = LOG_MAX + 1;

  logic signed [AW-1:0] acc_p0, acc_base, acc_sum, acc_nxt, din_ext;
  logic [CW-1:0]        cnt_p0, cnt_base, cnt_inc, cnt_nxt, target;
  logic [2:0]           lat_p0, l_eff, l_clamp;
  logic                 done;
  logic signed [OW-1:0] scaled, dout_p1;
  logic                 vld_p1;
`ifdef PI_SIG_OFFSET_EN
  logic                 clip, sat_p1;
`endif

  always_comb begin
    l_clamp  = (int'(log_dec) > LOG_MAX) ? 3'(LOG_MAX) : log_dec;
    // Window length is fixed at the window's first sample; sync opens a new window.
    l_eff    = (sync || cnt_p0 == '0) ? l_clamp : lat_p0;
    acc_base = sync ? '0 : acc_p0;
    cnt_base = sync ? '0 : cnt_p0;
    din_ext  = {{LOG_MAX{bus.din[DW-1]}}, bus.din};
    acc_sum  = acc_base + din_ext;
    cnt_inc  = cnt_base + CW'(1);
    target   = CW'(1) << l_eff;
    done     = enable && bus.din_valid && (cnt_inc == target);
    acc_nxt  = acc_base;
    cnt_nxt  = cnt_base;
    if (!enable || done) begin
      acc_nxt = '0;
      cnt_nxt = '0;
    end else if (bus.din_valid) begin
      acc_nxt = acc_sum;
      cnt_nxt = cnt_inc;
    end
  end

  pi_sig_scale #(.DW(DW), .OW(OW), .LOG_MAX(LOG_MAX)) u_scale (
    .acc_final (acc_sum),
    .shift     (l_eff),
`ifdef PI_SIG_OFFSET_EN
    .offset    (offset),
    .clip      (clip),
`endif
    .result    (scaled)
  );

  // p0: accumulator/counter  ->  p1: registered average and strobe
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_p0  <= '0;
      cnt_p0  <= '0;
      lat_p0  <= '0;
      dout_p1 <= '0;
      vld_p1  <= 1'b0;
`ifdef PI_SIG_OFFSET_EN
      sat_p1  <= 1'b0;
`endif
    end else begin
      acc_p0 <= acc_nxt;
      cnt_p0 <= cnt_nxt;
      lat_p0 <= l_eff;
      vld_p1 <= done;
      if (done) dout_p1 <= scaled;
`ifdef PI_SIG_OFFSET_EN
      sat_p1 <= (sync ? 1'b0 : sat_p1) | (done & clip);
`endif
    end
  end

  assign bus.dout       = dout_p1;
  assign bus.strobe_out = vld_p1;
`ifdef PI_SIG_OFFSET_EN
  assign bus.sat        = sat_p1;
`else
  assign bus.sat        = 1'b0;
`endif

endmodule
